// File: rtl/mips_mem_responder_if.sv
// Request/response bus between the multicycle MIPS core (master) and its
// memory responder (slave).
interface mips_mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  busy, resp_ready, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output busy, resp_ready, resp_rdata, resp_err
  );
endinterface

// File: rtl/mips_mem_responder.sv
// Unified I/D memory responder: one word access at a time, programmable wait
// states, error flag for misaligned/out-of-range, side-band debug read port.
module mips_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                reset,
  mips_mem_responder_if.slave bus,
  output logic [15:0]         access_cnt,
  input  logic [31:0]         dbg_addr,
  output logic [31:0]         dbg_rdata
);
  localparam int         AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] acc_q, acc_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          commit;
  logic          c_wr, c_err, mem_we;
  logic [31:0]   c_addr, c_wdata;
  logic [AW-1:0] c_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            cnt_d   = WS;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is the acceptance edge, so the
  // live request must be used instead of the (not yet loaded) holding regs.
  always_comb begin
    c_wr    = (state_q == S_IDLE) ? bus.req_write : wr_q;
    c_addr  = (state_q == S_IDLE) ? bus.req_addr  : addr_q;
    c_wdata = (state_q == S_IDLE) ? bus.req_wdata : wdata_q;
    c_err   = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= 30'(DEPTH_WORDS));
    c_idx   = c_addr[AW+1:2];
    mem_we  = commit && c_wr && !c_err;
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    acc_d   = acc_q;
    if (commit) begin
      err_d = c_err;
      if (c_err) begin
        rdata_d = '0;
      end else begin
        if (!c_wr) rdata_d = mem[c_idx];
        if (acc_q != 16'hFFFF) acc_d = acc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) mem[c_idx] <= c_wdata;
  end

  assign dbg_rdata = (dbg_addr < 32'(DEPTH_WORDS)) ? mem[dbg_addr[AW-1:0]] : '0;

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.resp_ready = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign access_cnt     = acc_q;
endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Unified instruction/data memory responder for the multicycle MIPS core: the slave end of the core's memory request interface. Accepts one word-aligned read or write request at a time and returns a single-cycle response after a programmable number of wait states. Flags misaligned and out-of-range accesses. Exposes a side-band debug read port so the bench can inspect memory contents without disturbing the core.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words; valid word index range is 0..DEPTH_WORDS-1.
- WAIT_STATES, 2, extra cycles between request acceptance and response; legal range 0..15.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  request present; sampled only in IDLE.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address; the word index is req_addr[31:2].
- req_wdata  input  32  write data.
- busy  output  1  high in WAIT and RESP.
- resp_ready  output  1  one-cycle response strobe.
- resp_rdata  output  32  read data, registered.
- resp_err  output  1  error flag, valid with resp_ready.
- access_cnt  output  16  completed non-error accesses, saturating.
- dbg_addr  input  32  debug word index (not a byte address).
- dbg_rdata  output  32  combinational read of mem[dbg_addr]; 0 if dbg_addr >= DEPTH_WORDS.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE with req_valid=1: capture req_write, req_addr and req_wdata into holding registers.
  - WAIT_STATES=0: go to RESP.
  - Otherwise: load wait counter with WAIT_STATES and go to WAIT.
- IDLE with req_valid=0: stay in IDLE.
- WAIT: decrement the counter each cycle. When the counter equals 1, go to RESP on that edge.
- Commit happens on the edge that enters RESP.
  - Read: resp_rdata <= mem[index].
  - Write: mem[index] <= wdata. resp_rdata is not updated.
  - resp_err <= error condition.
  - access_cnt increments if there is no error.
- Error condition: captured addr[1:0] != 0, or index >= DEPTH_WORDS.
  - No memory write takes place.
  - resp_rdata <= 0.
  - access_cnt is unchanged.
- RESP lasts exactly one cycle, with resp_ready=1. The next state is always IDLE.
- req_valid is ignored in WAIT and RESP. The requester must hold the request until it observes resp_ready.
- resp_rdata and resp_err hold their values until the next commit.
- access_cnt saturates at 16'hFFFF.
- Memory array contents are not affected by reset. Contents are undefined until written (the bench preloads through writes).

## Timing
- Reset (reset=0), takes effect immediately and asynchronously:
  - state = IDLE
  - busy = 0
  - resp_ready = 0
  - resp_rdata = 0
  - resp_err = 0
  - access_cnt = 0
  - wait counter = 0
- Request sampled at edge k. resp_ready is high for the single cycle following edge k+WAIT_STATES.
- Latency is WAIT_STATES+1 cycles from the sampling edge to the end of the response cycle.
- busy rises after edge k and falls after edge k+WAIT_STATES+1.
- Back-to-back: the earliest next acceptance is edge k+WAIT_STATES+2 (the IDLE cycle after RESP). Peak throughput is one access per WAIT_STATES+2 cycles.
- Reset asserted in WAIT: the pending write is dropped (memory unchanged) and no response is produced.
- Reset asserted in RESP: the commit has already happened. resp_ready, resp_rdata and resp_err clear to 0.
- dbg_rdata reflects a write in the cycle after the commit edge.

## Test plan
- Write then read, WAIT_STATES=2:
  - Stimulus: write 32'hDEADBEEF to 0x10, then read 0x10.
  - Required: resp_ready pulses 3 cycles after each acceptance edge; read resp_rdata=32'hDEADBEEF, resp_err=0; access_cnt=2; dbg_addr=4 gives 32'hDEADBEEF.
- Latency sweep, WAIT_STATES=0 and 5:
  - Stimulus: issue a read with each setting.
  - Required: resp_ready is high for exactly 1 cycle, after edge k and after edge k+5 respectively; busy is high for 1 and 6 cycles.
- Misaligned access:
  - Stimulus: write 32'h12345678 to 0x13.
  - Required: resp_err=1, resp_rdata=0, mem[4] unchanged, access_cnt unchanged.
- Out-of-range access, DEPTH_WORDS=256:
  - Stimulus: read 0x400.
  - Required: resp_err=1, resp_rdata=0. A following read of 0x0 returns resp_err=0.
- Request while busy:
  - Stimulus: pulse req_valid with a different address during WAIT.
  - Required: the pulse is ignored; exactly one resp_ready, carrying the original request's data.
- Reset mid-operation:
  - Stimulus: write 32'hCAFEF00D to 0x20, assert reset=0 for 1 cycle during WAIT.
  - Required: all outputs return to their reset values immediately; no resp_ready; a later read of 0x20 returns the prior contents.
